// File: rtl/switch_allocator.sv
// Per-switch allocator: serializes header route lookups round-robin and grants
// crossbar outputs round-robin, holding each output until the packet's tail passes.
module switch_allocator #(
  parameter int unsigned PORTS_NUM = 5,
  parameter int unsigned ADDR_SIZE = 4,
  parameter int unsigned SEL_W     = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PORTS_NUM-1:0]           hdr_valid,
  input  logic [PORTS_NUM*ADDR_SIZE-1:0] hdr_dest,
  input  logic [PORTS_NUM-1:0]           flit_fire,
  input  logic [PORTS_NUM-1:0]           flit_tail,
  output logic [ADDR_SIZE-1:0]           rt_dest,
  input  logic [3:0]                     rt_port,
  output logic [PORTS_NUM-1:0]           in_granted,
  output logic [PORTS_NUM-1:0]           in_drop,
  output logic [PORTS_NUM-1:0]           out_busy,
  output logic [PORTS_NUM*SEL_W-1:0]     xbar_sel,
  output logic                           route_err
);

  typedef enum logic [2:0] {IDLE, LOOKUP, REQ, ACTIVE, DROP} state_t;

  state_t               st      [PORTS_NUM];
  logic [SEL_W-1:0]     route   [PORTS_NUM];
  logic [SEL_W-1:0]     out_ptr [PORTS_NUM];
  logic [SEL_W-1:0]     lk_ptr;

  logic                 lk_found;
  logic [SEL_W-1:0]     lk_win;
  logic                 rt_ok;
  logic [PORTS_NUM-1:0] gnt_found;
  logic [SEL_W-1:0]     gnt_win [PORTS_NUM];

  // (base + off) mod PORTS_NUM, valid for base < PORTS_NUM and off < PORTS_NUM
  function automatic logic [SEL_W-1:0] wrap_add(logic [SEL_W-1:0] base, int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= PORTS_NUM) s = s - PORTS_NUM;
    return SEL_W'(s);
  endfunction

  // Lookup arbiter: first input in LOOKUP at or after lk_ptr
  always_comb begin
    logic [SEL_W-1:0] idx;
    lk_found = 1'b0;
    lk_win   = '0;
    idx      = '0;
    for (int unsigned off = 0; off < PORTS_NUM; off++) begin
      idx = wrap_add(lk_ptr, off);
      if (!lk_found && st[idx] == LOOKUP) begin
        lk_found = 1'b1;
        lk_win   = idx;
      end
    end
  end

  assign rt_dest = (lk_found && !rst) ? hdr_dest[32'(lk_win)*ADDR_SIZE +: ADDR_SIZE] : '0;
  assign rt_ok   = 32'(rt_port) < PORTS_NUM;

  // Output allocators: per free output, first REQ input routed to it at or after out_ptr
  always_comb begin
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int unsigned j = 0; j < PORTS_NUM; j++) begin
      gnt_found[j] = 1'b0;
      gnt_win[j]   = '0;
      if (!out_busy[j]) begin
        for (int unsigned off = 0; off < PORTS_NUM; off++) begin
          idx = wrap_add(out_ptr[j], off);
          if (!gnt_found[j] && st[idx] == REQ && 32'(route[idx]) == j) begin
            gnt_found[j] = 1'b1;
            gnt_win[j]   = idx;
          end
        end
      end
    end
  end

  // Per-input FSMs, pointers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < PORTS_NUM; i++) begin
        st[i]      <= IDLE;
        route[i]   <= '0;
        out_ptr[i] <= '0;
      end
      lk_ptr     <= '0;
      in_granted <= '0;
      in_drop    <= '0;
      out_busy   <= '0;
      xbar_sel   <= '0;
      route_err  <= 1'b0;
    end else begin
      route_err <= 1'b0;

      for (int unsigned i = 0; i < PORTS_NUM; i++) begin
        case (st[i])
          IDLE: begin
            if (hdr_valid[i]) st[i] <= LOOKUP;
          end
          ACTIVE: begin
            if (flit_fire[i] && flit_tail[i]) begin
              st[i]              <= IDLE;
              in_granted[i]      <= 1'b0;
              out_busy[route[i]] <= 1'b0;
            end
          end
          DROP: begin
            if (flit_fire[i] && flit_tail[i]) begin
              st[i]         <= IDLE;
              in_granted[i] <= 1'b0;
              in_drop[i]    <= 1'b0;
            end
          end
          default: ;
        endcase
      end

      if (lk_found) begin
        lk_ptr <= wrap_add(lk_win, 1);
        if (rt_ok) begin
          st[lk_win]    <= REQ;
          route[lk_win] <= SEL_W'(rt_port);
        end else begin
          // Unroutable header: accept and discard the whole packet
          st[lk_win]         <= DROP;
          in_granted[lk_win] <= 1'b1;
          in_drop[lk_win]    <= 1'b1;
          route_err          <= 1'b1;
        end
      end

      for (int unsigned j = 0; j < PORTS_NUM; j++) begin
        if (gnt_found[j]) begin
          st[gnt_win[j]]             <= ACTIVE;
          in_granted[gnt_win[j]]     <= 1'b1;
          out_busy[j]                <= 1'b1;
          xbar_sel[j*SEL_W +: SEL_W] <= gnt_win[j];
          out_ptr[j]                 <= wrap_add(gnt_win[j], 1);
        end
      end
    end
  end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Per-switch controller that sequences the shared route-table lookup and allocates crossbar outputs to input ports.
- Sits between the input buffers and the crossbar inside each switch, and drives the single combinational route-table lookup.
- Serializes header lookups, one per cycle, by round-robin.
- Arbitrates each output port round-robin and holds an output locked until the packet's tail flit has passed.

Parameters:
- PORTS_NUM, 5, number of input and output ports (port index = routing port number).
- ADDR_SIZE, 4, width of a switch address.
- SEL_W, 3, width of a port index; must be ≥ clog2(PORTS_NUM).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- hdr_valid  input  PORTS_NUM  input i has a header flit at its buffer head; held until in_granted[i].
- hdr_dest  input  PORTS_NUM*ADDR_SIZE  destination switch of input i's header; slice i*ADDR_SIZE.
- flit_fire  input  PORTS_NUM  a flit of input i is transferred this cycle.
- flit_tail  input  PORTS_NUM  the fired flit of input i is a tail; qualified by flit_fire.
- rt_dest  output  ADDR_SIZE  address driven to the route lookup.
- rt_port  input  4  route lookup result, combinational from rt_dest.
- in_granted  output  PORTS_NUM  input i may forward, or is draining a dropped packet.
- in_drop  output  PORTS_NUM  input i's current packet is being discarded.
- out_busy  output  PORTS_NUM  output j is locked to an input.
- xbar_sel  output  PORTS_NUM*SEL_W  input index selected for output j; slice j*SEL_W.
- route_err  output  1  one-cycle pulse when a lookup returns rt_port ≥ PORTS_NUM.

Behaviour:
- Clock and reset: one clock domain, clk.
  - rst is synchronous and active-high.
  - During reset, every input FSM goes to IDLE and all round-robin pointers go to 0.
  - Reset values: in_granted=0, in_drop=0, out_busy=0, xbar_sel=0, route_err=0, rt_dest=0.
  - Reset mid-packet abandons all locks; no partial state survives.
- Per-input FSM:
  - IDLE: if hdr_valid[i], go to LOOKUP.
  - LOOKUP: waits for the lookup slot.
  - REQ: has a registered route port, requests that output.
  - ACTIVE: output locked, in_granted=1.
  - DROP: in_granted=1, in_drop=1.
- Lookup arbiter (combinational):
  - Among inputs in LOOKUP, pick the first at or after lk_ptr, wrapping.
  - rt_dest = winner's hdr_dest; rt_dest = 0 when there is no winner.
  - On the clock edge, the winner registers rt_port.
    - If rt_port < PORTS_NUM: go to REQ.
    - Otherwise: go to DROP and pulse route_err for the next cycle.
  - lk_ptr becomes winner+1 mod PORTS_NUM. It is unchanged if there is no winner.
- Output allocator, per output j, when not out_busy[j]:
  - Candidates are inputs in REQ whose route equals j.
  - Pick the first at or after ptr_j, wrapping.
  - On the edge: winner goes to ACTIVE, out_busy[j]=1, xbar_sel[j]=winner, ptr_j=winner+1 mod PORTS_NUM.
  - Different outputs grant independently in the same cycle. Each input requests one output only, so there is no double grant.
  - Inputs that lose stay in REQ.
- Release:
  - In ACTIVE or DROP, flit_fire & flit_tail returns the input to IDLE on the next edge.
  - In the ACTIVE case, out_busy[j] clears on that same edge.
  - The freed output is available for a new grant in the following cycle, so there is no same-cycle release-and-grant.
  - flit_fire without flit_tail keeps the state.
  - flit_fire while not in ACTIVE or DROP is ignored.
- Single-flit packets: header=tail, fired in ACTIVE, released like any tail.
- Latency with no contention:
  - hdr_valid rises in cycle 0.
  - Cycle 1: LOOKUP.
  - Cycle 2: REQ.
  - Cycle 3: ACTIVE, in_granted=1.
  - Tail fire in cycle k gives IDLE and out_busy=0 at k+1.
- xbar_sel[j] keeps its last value after release. It is meaningful only while out_busy[j] is high.
- U-turn (route j == i) is legal and granted normally.

Test Plan:
- Single route: reset; input 0 hdr_dest=5, lookup returns 2 → rt_dest=5 in cycle 1; in_granted[0]=1, out_busy[2]=1, xbar_sel[2]=0 in cycle 3; tail fire in cycle 6 → out_busy[2]=0 in cycle 7.
- Lookup serialization: inputs 0,1,3 all raise hdr_valid in cycle 0 → lookups in cycles 1,2,3 in order 0,1,3; lk_ptr then =4.
- Output contention: inputs 1 and 3 both route to output 4, ptr_4=0 → input 1 is granted. Input 1's tail releases output 4; input 3 is granted the cycle after release. Repeat with ptr_4=2 → input 3 wins first.
- Bad route: lookup returns 7 → route_err pulses once, in_drop=1, in_granted=1, no out_busy change; tail fire → IDLE, in_drop=0.
- Parallel grants: inputs 0→1 and 2→3 in REQ together → both granted in the same cycle; a mid-packet non-tail flit_fire keeps the locks.
- Reset mid-packet: rst for 1 cycle while two outputs are busy → all outputs at reset values next cycle. An input with hdr_valid still high restarts the lookup in the cycle after rst drops.
